// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, register index width, RV32I opcodes.
package cpu_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam int unsigned REG_W        = 5;
   localparam int unsigned INSTR_W      = 32;
   localparam int unsigned OPC_W        = 7;

   localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_OP     = 7'b0110011;

   // Occupancy of the ID/EX pipeline register.
   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } pipe_state_t;

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate decoder, sign-extended to XLEN; shared with the branch unit.
module imm_gen
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic [INSTR_W-1:0] instr,
   output logic [XLEN-1:0]    imm
);

   logic [31:0] imm32;

   // Select the immediate format from the opcode.
   always_comb begin
      imm32 = '0;
      case (instr[6:0])
         OP_LUI, OP_AUIPC:
            imm32 = {instr[31:12], 12'b0};
         OP_JAL:
            imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         OP_JALR, OP_LOAD, OP_IMM:
            imm32 = {{20{instr[31]}}, instr[31:20]};
         OP_STORE:
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OP_BRANCH:
            imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         default:
            imm32 = '0;
      endcase
   end

   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_ex_stage.sv
// Decode/operand stage: register-file read, forwarding, load-use stall, ID/EX register.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_instr,
   input  logic [31:0]        in_pc,
   input  logic               flush,
   output logic [REG_W-1:0]   rf_raddr1,
   output logic [REG_W-1:0]   rf_raddr2,
   input  logic [XLEN-1:0]    rf_rdata1,
   input  logic [XLEN-1:0]    rf_rdata2,
   input  logic               ex_valid,
   input  logic               ex_regwrite,
   input  logic               ex_is_load,
   input  logic [REG_W-1:0]   ex_rd,
   input  logic [XLEN-1:0]    ex_result,
   input  logic               wb_regwrite,
   input  logic [REG_W-1:0]   wb_rd,
   input  logic [XLEN-1:0]    wb_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_pc,
   output logic [XLEN-1:0]    out_rs1_val,
   output logic [XLEN-1:0]    out_rs2_val,
   output logic [XLEN-1:0]    out_imm,
   output logic [REG_W-1:0]   out_rd,
   output logic [2:0]         out_funct3,
   output logic               out_funct7b5,
   output logic [OPC_W-1:0]   out_opcode,
   output logic               out_rd_we
);

   pipe_state_t      state;
   logic [REG_W-1:0] rs1, rs2, rd;
   logic [OPC_W-1:0] opcode;
   logic [XLEN-1:0]  imm;
   logic [XLEN-1:0]  rs1_val, rs2_val;
   logic             rd_we;
   logic             ex_fwd_ok;
   logic             hazard, advance, accept;

   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];
   assign rd     = in_instr[11:7];
   assign opcode = in_instr[6:0];

   assign rf_raddr1 = rs1;
   assign rf_raddr2 = rs2;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (in_instr),
      .imm   (imm)
   );

   // A load in execute has no result yet, so it never forwards from there.
   assign ex_fwd_ok = ex_valid && ex_regwrite && !ex_is_load;

   // Operand mux: x0, then execute, then writeback (same-edge RF write), then RF.
   function automatic logic [XLEN-1:0] sel_operand(
      input logic [REG_W-1:0] rs,
      input logic [XLEN-1:0]  rf_val
   );
      if (rs == '0)
         return '0;
      else if (ex_fwd_ok && (ex_rd == rs))
         return ex_result;
      else if (wb_regwrite && (wb_rd == rs))
         return wb_data;
      else
         return rf_val;
   endfunction

   // Source operand selection for both read ports.
   always_comb begin
      rs1_val = sel_operand(rs1, rf_rdata1);
      rs2_val = sel_operand(rs2, rf_rdata2);
   end

   assign rd_we = (opcode != OP_STORE) && (opcode != OP_BRANCH) && (rd != '0);

   // Load-use check compares both sources regardless of instruction format.
   assign hazard  = in_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                    ((ex_rd == rs1) || (ex_rd == rs2));
   assign advance = (state == S_EMPTY) || out_ready;
   assign in_ready = advance && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   assign out_valid = (state == S_FULL);

   // ID/EX register: flush empties it, advance loads or bubbles, otherwise hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_EMPTY;
         out_pc       <= '0;
         out_rs1_val  <= '0;
         out_rs2_val  <= '0;
         out_imm      <= '0;
         out_rd       <= '0;
         out_funct3   <= '0;
         out_funct7b5 <= 1'b0;
         out_opcode   <= '0;
         out_rd_we    <= 1'b0;
      end else begin
         if (flush)
            state <= S_EMPTY;
         else if (advance)
            state <= accept ? S_FULL : S_EMPTY;

         if (accept) begin
            out_pc       <= XLEN'(in_pc);
            out_rs1_val  <= rs1_val;
            out_rs2_val  <= rs2_val;
            out_imm      <= imm;
            out_rd       <= rd;
            out_funct3   <= in_instr[14:12];
            out_funct7b5 <= in_instr[30];
            out_opcode   <= opcode;
            out_rd_we    <= rd_we;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table, directed sequences, random vs. model.
module tb_id_ex_stage;
   import cpu_pkg::*;

   localparam int unsigned XLEN = 32;

   logic              clk;
   logic              reset_n;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [31:0]       in_pc;
   logic              flush;
   logic [4:0]        rf_raddr1, rf_raddr2;
   logic [XLEN-1:0]   rf_rdata1, rf_rdata2;
   logic              ex_valid, ex_regwrite, ex_is_load;
   logic [4:0]        ex_rd;
   logic [XLEN-1:0]   ex_result;
   logic              wb_regwrite;
   logic [4:0]        wb_rd;
   logic [XLEN-1:0]   wb_data;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_pc, out_rs1_val, out_rs2_val, out_imm;
   logic [4:0]        out_rd;
   logic [2:0]        out_funct3;
   logic              out_funct7b5;
   logic [6:0]        out_opcode;
   logic              out_rd_we;

   id_ex_stage #(.XLEN(XLEN)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .flush        (flush),
      .rf_raddr1    (rf_raddr1),
      .rf_raddr2    (rf_raddr2),
      .rf_rdata1    (rf_rdata1),
      .rf_rdata2    (rf_rdata2),
      .ex_valid     (ex_valid),
      .ex_regwrite  (ex_regwrite),
      .ex_is_load   (ex_is_load),
      .ex_rd        (ex_rd),
      .ex_result    (ex_result),
      .wb_regwrite  (wb_regwrite),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_rs1_val  (out_rs1_val),
      .out_rs2_val  (out_rs2_val),
      .out_imm      (out_imm),
      .out_rd       (out_rd),
      .out_funct3   (out_funct3),
      .out_funct7b5 (out_funct7b5),
      .out_opcode   (out_opcode),
      .out_rd_we    (out_rd_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_valid    = 1'b0;
      in_instr    = 32'h0000_0013;
      in_pc       = '0;
      flush       = 1'b0;
      out_ready   = 1'b1;
      rf_rdata1   = '0;
      rf_rdata2   = '0;
      ex_valid    = 1'b0;
      ex_regwrite = 1'b0;
      ex_is_load  = 1'b0;
      ex_rd       = '0;
      ex_result   = '0;
      wb_regwrite = 1'b0;
      wb_rd       = '0;
      wb_data     = '0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_pc"},    out_pc, 32'd0);
      chk({tag, "_rs1"},   out_rs1_val, 32'd0);
      chk({tag, "_rs2"},   out_rs2_val, 32'd0);
      chk({tag, "_imm"},   out_imm, 32'd0);
      chk({tag, "_rd"},    32'(out_rd), 32'd0);
      chk({tag, "_f3"},    32'(out_funct3), 32'd0);
      chk({tag, "_f7"},    32'(out_funct7b5), 32'd0);
      chk({tag, "_op"},    32'(out_opcode), 32'd0);
      chk({tag, "_we"},    32'(out_rd_we), 32'd0);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc, rs1, rs2, imm;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        f7;
      logic [6:0]  op;
      logic        we;
   } bundle_t;

   logic    m_valid;
   bundle_t m_b;

   // Immediate built from arithmetic shifts of the signed instruction word.
   function automatic logic [31:0] ref_imm(input logic [31:0] ins);
      logic signed [31:0] s;
      logic [6:0]         op;
      s  = ins;
      op = ins[6:0];
      if (op == OP_LUI || op == OP_AUIPC)
         return ins & 32'hFFFF_F000;
      if (op == OP_IMM || op == OP_LOAD || op == OP_JALR)
         return 32'(s >>> 20);
      if (op == OP_STORE)
         return 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
      if (op == OP_BRANCH)
         return 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) |
                (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      if (op == OP_JAL)
         return 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) |
                (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      return 32'd0;
   endfunction

   function automatic logic [31:0] ref_opnd(input logic [4:0] rs, input logic [31:0] rf);
      if (rs == 5'd0) return 32'd0;
      if (ex_valid && ex_regwrite && !ex_is_load && ex_rd == rs) return ex_result;
      if (wb_regwrite && wb_rd == rs) return wb_data;
      return rf;
   endfunction

   function automatic logic ref_hazard();
      logic [4:0] a, b;
      a = in_instr[19:15];
      b = in_instr[24:20];
      return in_valid && ex_valid && ex_is_load && ex_rd != 5'd0 && (ex_rd == a || ex_rd == b);
   endfunction

   function automatic logic ref_ready();
      return (!m_valid || out_ready) && !ref_hazard() && !flush;
   endfunction

   function automatic bundle_t ref_bundle();
      bundle_t b;
      logic [6:0] op;
      op    = in_instr[6:0];
      b.pc  = in_pc;
      b.rs1 = ref_opnd(in_instr[19:15], rf_rdata1);
      b.rs2 = ref_opnd(in_instr[24:20], rf_rdata2);
      b.imm = ref_imm(in_instr);
      b.rd  = in_instr[11:7];
      b.f3  = in_instr[14:12];
      b.f7  = in_instr[30];
      b.op  = op;
      b.we  = !(op == OP_STORE || op == OP_BRANCH) && (in_instr[11:7] != 5'd0);
      return b;
   endfunction

   // Advance the model across one clock edge using the currently driven inputs.
   task automatic model_edge();
      logic acc;
      acc = in_valid && ref_ready();
      if (flush)
         m_valid = 1'b0;
      else if (!m_valid || out_ready) begin
         m_valid = acc;
         if (acc) m_b = ref_bundle();
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         chk({tag, "_pc"},  out_pc, m_b.pc);
         chk({tag, "_rs1"}, out_rs1_val, m_b.rs1);
         chk({tag, "_rs2"}, out_rs2_val, m_b.rs2);
         chk({tag, "_imm"}, out_imm, m_b.imm);
         chk({tag, "_rd"},  32'(out_rd), 32'(m_b.rd));
         chk({tag, "_f3"},  32'(out_funct3), 32'(m_b.f3));
         chk({tag, "_f7"},  32'(out_funct7b5), 32'(m_b.f7));
         chk({tag, "_op"},  32'(out_opcode), 32'(m_b.op));
         chk({tag, "_we"},  32'(out_rd_we), 32'(m_b.we));
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0] instr, rf1, rf2;
      logic        exv, exw, exl;
      logic [4:0]  exrd;
      logic [31:0] exres;
      logic        wbw;
      logic [4:0]  wbrd;
      logic [31:0] wbd;
      logic [31:0] e_rs1, e_rs2, e_imm;
      logic [4:0]  e_rd;
      logic        e_we;
   } vec_t;

   localparam int NVEC = 14;
   vec_t vt [NVEC];

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ins;
      logic [31:0] rnd;
      logic [6:0]  ops [10];

      // ADDI, ADD with ex/wb forwarding variants, stores, branch, LUI, JAL, AUIPC x0, LW, JALR, unknown
      vt[0]  = '{32'hFFC00293, 32'h1234, 32'h55,   0,0,0, 5'd0, 32'h0,   0,5'd0,32'h0,  32'h0,    32'h55,   32'hFFFFFFFC, 5'd5,  1'b1};
      vt[1]  = '{32'h004180B3, 32'h11,   32'h44,   1,1,0, 5'd3, 32'h22,  1,5'd3,32'h33, 32'h22,   32'h44,   32'h0,        5'd1,  1'b1};
      vt[2]  = '{32'h004180B3, 32'h11,   32'h44,   0,1,0, 5'd3, 32'h22,  1,5'd3,32'h33, 32'h33,   32'h44,   32'h0,        5'd1,  1'b1};
      vt[3]  = '{32'h004180B3, 32'h11,   32'h44,   1,1,0, 5'd3, 32'h22,  1,5'd4,32'h99, 32'h22,   32'h99,   32'h0,        5'd1,  1'b1};
      vt[4]  = '{32'h004180B3, 32'h11,   32'h44,   1,0,0, 5'd3, 32'h22,  0,5'd0,32'h0,  32'h11,   32'h44,   32'h0,        5'd1,  1'b1};
      vt[5]  = '{32'h00612423, 32'h1000, 32'h2000, 0,0,0, 5'd0, 32'h0,   0,5'd0,32'h0,  32'h1000, 32'h2000, 32'h8,        5'd8,  1'b0};
      vt[6]  = '{32'hFE612E23, 32'h1000, 32'h2000, 0,0,0, 5'd0, 32'h0,   0,5'd0,32'h0,  32'h1000, 32'h2000, 32'hFFFFFFFC, 5'd28, 1'b0};
      vt[7]  = '{32'hFE208CE3, 32'h1,    32'h2,    0,0,0, 5'd0, 32'h0,   0,5'd0,32'h0,  32'h1,    32'h2,    32'hFFFFFFF8, 5'd25, 1'b0};
      vt[8]  = '{32'h12345537, 32'hA,    32'hB,    0,0,0, 5'd0, 32'h0,   0,5'd0,32'h0,  32'hA,    32'hB,    32'h12345000, 5'd10, 1'b1};
      vt[9]  = '{32'hFFDFF0EF, 32'h1,    32'h2,    0,0,0, 5'd0, 32'h0,   0,5'd0,32'h0,  32'h1,    32'h2,    32'hFFFFFFFC, 5'd1,  1'b1};
      vt[10] = '{32'h80000017, 32'hDEAD, 32'hBEEF, 0,0,0, 5'd0, 32'h0,   1,5'd0,32'h77, 32'h0,    32'h0,    32'h80000000, 5'd0,  1'b0};
      vt[11] = '{32'h7FF42383, 32'h8888, 32'h3,    1,1,1, 5'd9, 32'h55,  0,5'd0,32'h0,  32'h8888, 32'h3,    32'h7FF,      5'd7,  1'b1};
      vt[12] = '{32'h00008067, 32'h40,   32'h0,    0,0,0, 5'd0, 32'h0,   1,5'd1,32'h50, 32'h50,   32'h0,    32'h0,        5'd0,  1'b0};
      vt[13] = '{32'hFFFFFFFF, 32'h7,    32'h8,    1,1,0, 5'd31,32'h123, 0,5'd0,32'h0,  32'h123,  32'h123,  32'h0,        5'd31, 1'b1};

      ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP, 7'b1111111};

      // ---- reset ----
      clear_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      chk_zero("reset");
      reset_n = 1'b1;
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);

      // ---- vector table, out_ready held high ----
      for (int i = 0; i < NVEC; i++) begin
         clear_inputs();
         in_valid    = 1'b1;
         in_instr    = vt[i].instr;
         in_pc       = 32'h1000 + 32'(i) * 4;
         rf_rdata1   = vt[i].rf1;
         rf_rdata2   = vt[i].rf2;
         ex_valid    = vt[i].exv;
         ex_regwrite = vt[i].exw;
         ex_is_load  = vt[i].exl;
         ex_rd       = vt[i].exrd;
         ex_result   = vt[i].exres;
         wb_regwrite = vt[i].wbw;
         wb_rd       = vt[i].wbrd;
         wb_data     = vt[i].wbd;
         ins         = vt[i].instr;
         #1;
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
         chk($sformatf("vec%0d_raddr1", i), 32'(rf_raddr1), 32'(ins[19:15]));
         chk($sformatf("vec%0d_raddr2", i), 32'(rf_raddr2), 32'(ins[24:20]));
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d_pc", i),    out_pc, 32'h1000 + 32'(i) * 4);
         chk($sformatf("vec%0d_rs1", i),   out_rs1_val, vt[i].e_rs1);
         chk($sformatf("vec%0d_rs2", i),   out_rs2_val, vt[i].e_rs2);
         chk($sformatf("vec%0d_imm", i),   out_imm, vt[i].e_imm);
         chk($sformatf("vec%0d_rd", i),    32'(out_rd), 32'(vt[i].e_rd));
         chk($sformatf("vec%0d_we", i),    32'(out_rd_we), 32'(vt[i].e_we));
         chk($sformatf("vec%0d_f3", i),    32'(out_funct3), 32'(ins[14:12]));
         chk($sformatf("vec%0d_f7", i),    32'(out_funct7b5), 32'(ins[30]));
         chk($sformatf("vec%0d_op", i),    32'(out_opcode), 32'(ins[6:0]));
      end

      // ---- load-use: stall one cycle, then take the value from writeback ----
      clear_inputs();
      in_valid    = 1'b1;
      in_instr    = 32'h007100B3;
      in_pc       = 32'h200;
      rf_rdata2   = 32'hDEAD;
      ex_valid    = 1'b1;
      ex_regwrite = 1'b1;
      ex_is_load  = 1'b1;
      ex_rd       = 5'd7;
      ex_result   = 32'hBAD;
      #1;
      chk("lu_stall_ready", 32'(in_ready), 32'd0);
      tick();
      chk("lu_bubble", 32'(out_valid), 32'd0);
      ex_valid    = 1'b0;
      ex_is_load  = 1'b0;
      wb_regwrite = 1'b1;
      wb_rd       = 5'd7;
      wb_data     = 32'hAB;
      #1;
      chk("lu_retry_ready", 32'(in_ready), 32'd1);
      tick();
      chk("lu_valid", 32'(out_valid), 32'd1);
      chk("lu_rs2",   out_rs2_val, 32'hAB);
      chk("lu_pc",    out_pc, 32'h200);

      // ---- backpressure: hold three cycles, then release ----
      clear_inputs();
      in_valid = 1'b1;
      in_instr = 32'hFFC00293;
      in_pc    = 32'h300;
      tick();
      chk("bp_load_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b0;
      in_instr  = 32'h12345537;
      in_pc     = 32'h304;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
         tick();
         chk($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("bp%0d_pc", k),    out_pc, 32'h300);
         chk($sformatf("bp%0d_imm", k),   out_imm, 32'hFFFFFFFC);
         chk($sformatf("bp%0d_rd", k),    32'(out_rd), 32'd5);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      tick();
      chk("bp_next_valid", 32'(out_valid), 32'd1);
      chk("bp_next_pc",    out_pc, 32'h304);
      chk("bp_next_imm",   out_imm, 32'h12345000);

      // ---- flush while FULL and stalled downstream ----
      out_ready = 1'b0;
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 32'h004180B3;
      in_pc     = 32'h308;
      #1;
      chk("fl_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("fl_valid", 32'(out_valid), 32'd0);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("fl_after_valid", 32'(out_valid), 32'd0);

      // ---- randomized traffic against the reference model ----
      m_valid = 1'b0;
      m_b     = '{default: '0};
      for (int n = 0; n < 600; n++) begin
         rnd          = $urandom;
         ins          = $urandom;
         ins[6:0]     = ops[$urandom_range(0, 9)];
         ins[19:15]   = 5'($urandom_range(0, 7));
         ins[24:20]   = 5'($urandom_range(0, 7));
         ins[11:7]    = 5'($urandom_range(0, 7));
         in_instr     = ins;
         in_pc        = {$urandom, 2'b00} >> 2 << 2;
         in_valid     = ($urandom_range(0, 3) != 0);
         out_ready    = ($urandom_range(0, 3) != 0);
         flush        = ($urandom_range(0, 7) == 0);
         rf_rdata1    = $urandom;
         rf_rdata2    = $urandom;
         ex_valid     = rnd[0];
         ex_regwrite  = rnd[1] | rnd[2];
         ex_is_load   = (rnd[5:3] < 3'd3);
         ex_rd        = 5'($urandom_range(0, 7));
         ex_result    = $urandom;
         wb_regwrite  = rnd[6] | rnd[7];
         wb_rd        = 5'($urandom_range(0, 7));
         wb_data      = $urandom;
         #1;
         chk($sformatf("rnd%0d_in_ready", n), 32'(in_ready), 32'(ref_ready()));
         model_edge();
         tick();
         chk_model($sformatf("rnd%0d", n));
      end

      // ---- asynchronous reset mid-stream, no clock edge needed ----
      clear_inputs();
      in_valid = 1'b1;
      in_instr = 32'hFFC00293;
      in_pc    = 32'h400;
      tick();
      chk("mr_pre_valid", 32'(out_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk_zero("midreset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode/operand stage that sits between instruction fetch and execute, directly around the register file. It drives the register file's combinational read addresses, decodes the RV32I immediate, and forwards from execute and writeback. It stalls one cycle on a load-use hazard and registers a decoded operand bundle into the ID/EX pipeline register behind a valid/ready handshake.

## Interface
- XLEN, default 32, datapath width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid / in_ready  in/out  1  fetch handshake
- in_instr  in  32  instruction word
- in_pc  in  32  instruction PC
- flush  in  1  kill the output bundle; block acceptance this cycle
- rf_raddr1 / rf_raddr2  out  5  register-file read addresses, instr[19:15] / instr[24:20]
- rf_rdata1 / rf_rdata2  in  XLEN  register-file read data, same cycle
- ex_valid, ex_regwrite, ex_is_load  in  1  execute-stage producer info
- ex_rd  in  5, ex_result  in  XLEN  execute destination and result
- wb_regwrite  in  1, wb_rd  in  5, wb_data  in  XLEN  writeback port; also wired to the register-file write port
- out_valid / out_ready  out/in  1  execute handshake
- out_pc, out_rs1_val, out_rs2_val, out_imm  out  XLEN  registered operands
- out_rd  out  5, out_funct3  out  3, out_funct7b5  out  1, out_opcode  out  7, out_rd_we  out  1

## Operation
- Decoding is combinational from in_instr. rs1 = [19:15], rs2 = [24:20], rd = [11:7].
- Operand select, per source, in priority order:
  1. Address 0 gives 0.
  2. If ex_valid && ex_regwrite && !ex_is_load && ex_rd == rs, use ex_result.
  3. Else if wb_regwrite && wb_rd == rs, use wb_data.
  4. Else use rf_rdata.
- The writeback bypass is mandatory because the register-file write lands at the same edge.
- hazard = in_valid && ex_valid && ex_is_load && ex_rd != 0 && (ex_rd == rs1 || ex_rd == rs2). The check is conservative: both sources are compared for every format.
- Immediate by opcode:
  - LUI/AUIPC: U
  - JAL: J
  - JALR/LOAD/OP-IMM: I
  - STORE: S
  - BRANCH: B
  - anything else: 0
- All immediates are sign-extended to XLEN.
- out_rd_we = 1 unless opcode is STORE or BRANCH, or rd == 0.
- Output-register states: EMPTY (out_valid = 0) and FULL (out_valid = 1).
  - advance = !out_valid || out_ready
  - in_ready = advance && !hazard && !flush
  - accept = in_valid && in_ready

## Timing
- Reset (asynchronous, reset_n low): out_valid = 0 and every out_* data field = 0. Reset mid-transfer discards the bundle.
- Latency is 1 cycle: an accepted instruction appears on out_* at the next edge with out_valid = 1.
- On each edge with advance = 1:
  - if accept: load the bundle and set out_valid = 1;
  - else: out_valid = 0, a bubble; data fields may hold.
- When advance = 0 (FULL && !out_ready), all out_* hold and in_ready = 0.
- Hazard: in_ready = 0, and a bubble is inserted if advance. The next cycle the load sits in writeback and the value comes through the wb bypass.
- flush has priority over everything except reset. Next edge: out_valid = 0, regardless of out_ready. No instruction is accepted in the flush cycle.
- Simultaneous ex and wb match on the same rs: ex wins.
- The forwarding muxes sample inputs only in the accept cycle. Stale forwarding inputs while stalled are irrelevant.

## Structure
- cpu_pkg holds:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP);
  - the XLEN default;
  - the 5-bit register-index width.
- Sub-module imm_gen: purely combinational, instr in, imm out. It is reused by the branch unit.
- The forwarding muxes and the hazard detect stay inline.

## Test plan
- Reset: hold reset_n = 0 mid-stream -> out_valid = 0 and all out_* = 0 immediately, without waiting for a clock.
- ADDI x5, x0, -4 (0xFFC00293) with out_ready = 1 -> next cycle out_imm = 0xFFFFFFFC, out_rd = 5, out_rd_we = 1, out_rs1_val = 0.
- EX bypass: rf_rdata1 = 0x11, ex_rd = 3, ex_result = 0x22, wb_rd = 3, wb_data = 0x33, ADD x1, x3, x4 -> out_rs1_val = 0x22. With ex_valid = 0 instead -> 0x33.
- Load-use: ex_is_load = 1, ex_rd = 7, instruction reads x7 -> in_ready = 0 for one cycle and a bubble is emitted. Next cycle, with wb_rd = 7 and wb_data = 0xAB -> accepted, out_rs2_val or out_rs1_val = 0xAB.
- Backpressure: FULL with out_ready = 0 for 3 cycles -> out_* stable, in_ready = 0. out_ready = 1 -> the next instruction loads on the following edge.
- Flush while FULL and out_ready = 0 -> out_valid = 0 after one edge. A concurrent in_valid instruction is not accepted.
